seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
// - Time-multiplexed 4-digit 7-segment driver for the stopwatch display path; consumes the four BCD digits
//   (d0 tenths, d1 seconds units, d2 seconds tens, d3 minutes) and drives common-anode digit/segment pins.
// - Snapshots digits once per scan frame (no tearing mid-frame), decodes BCD, lights DP after d1 ("M SS.t").
// PARAMETERS
// - REFRESH_DIV  100_000  clk cycles per digit slot (frame = 4*REFRESH_DIV); must be >= 2
// - CNT_W        $clog2(REFRESH_DIV)  prescaler width (derived, localparam)
// PORTS
// - clk         in   1  system clock, single clock domain
// - reset_n     in   1  asynchronous, active-low reset
// - d0,d1,d2,d3 in   4  BCD digits from stopwatch (d0 rightmost)
// - blank       in   1  1 = all digits off (anodes high), scanning continues
// - an          out  4  digit enables, active-low, an[0] = d0 position
// - seg         out  7  segments active-low, seg[6:0] = {g,f,e,d,c,b,a}
// - dp          out  1  decimal point, active-low
// - frame_tick  out  1  one-cycle pulse when a new snapshot is taken
// BEHAVIOUR
// - Reset (async assert, sync-safe deassert by design): prescaler=0, idx=0, snap=0, an=4'b1111, seg=7'h7F,
//   dp=1, frame_tick=0. Reset mid-scan aborts immediately to these values.
// - Prescaler: counts 0..REFRESH_DIV-1, wraps to 0; slot_tick = (cnt==REFRESH_DIV-1).
// - idx (2b): on slot_tick idx <= idx+1 (wraps 3->0). Never changes otherwise.
// - Snapshot: on slot_tick with idx==3: snap <= {d3,d2,d1,d0}; frame_tick <= 1 for exactly that next cycle.
//   Inputs are sampled only there; changes between snapshots are invisible. First snapshot after reset at
//   cycle 4*REFRESH_DIV (slots before that show zeros).
// - Output stage: an/seg/dp registered every cycle from current (idx, snap, blank); 1-cycle latency from idx
//   change to pins. Exactly one anode low per cycle unless blanked.
// - Decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex). Invalid BCD 10..15 -> dash 3F.
// - dp=0 only when idx==1 and digit shown (not blanked); else 1.
// - blank=1: an=1111, seg=7F, dp=1 on next cycle; prescaler/idx/snapshot keep running.
// - Digit slot blanked: an bit stays 1, seg=7F, dp=1 (ghost-free).
// CONFIGURATION
// - LEADING_ZERO_BLANK_EN defined: snap d3==0 -> slot 3 blanked; d3==0 && d2==0 -> slot 2 blanked too;
//   slots 1 and 0 never blanked ("0.0" minimum display). Invalid BCD is never treated as zero.
// - Not defined: all four digits always shown, including leading zeros.
// TESTING (bench uses REFRESH_DIV=4: slot = 4 cycles, frame = 16 cycles)
// - Reset: reset_n=0 mid-scan -> same cycle an=1111 seg=7F dp=1 frame_tick=0; release -> slot 0 shows seg=40.
// - Snapshot: d3..d0=4,3,2,1 held from reset -> frame_tick at cycle 16; then an 1110/1101/1011/0111 every 4
//   cycles with seg 79/24(dp=0)/30/19.
// - Tearing: change d0 1->7 mid-frame -> pins keep 79 until next frame_tick, then slot 0 shows 78.
// - Invalid BCD: d2=4'hC -> slot 2 seg=3F, dp=1; other slots unaffected.
// - blank=1 for 10 cycles -> an=1111 throughout; on release scan resumes at correct idx, frame_tick period 16.
// - Macro: d3..d0=0,0,0,5 -> with LEADING_ZERO_BLANK_EN slots 3,2 an bits stay 1, slot1 seg=40 dp=0, slot0 seg=12;
//   without macro all four slots lit (40,40,40,12).

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed 4-digit common-anode 7-segment driver for the stopwatch
// display ("M SS.t"). The four BCD digits are snapshotted once per scan frame,
// so the display never tears mid-frame. All pins are active-low and registered.
//
// Build option: define LEADING_ZERO_BLANK_EN to blank a leading zero in the
// minutes slot, and also the seconds-tens slot when both are zero. Slots 1 and
// 0 are never blanked. Invalid BCD is never treated as zero.
//
// idx | slot driven
// ----+--------------------------------------------
//  0  | d0 tenths (rightmost, an[0])
//  1  | d1 seconds units, decimal point lit
//  2  | d2 seconds tens
//  3  | d3 minutes; its slot_tick takes the snapshot
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             slot_tick;
  logic [1:0]       idx;
  logic [15:0]      snap;
  logic [3:0]       digit;
  logic             slot_off;
  logic [6:0]       seg_dec;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  assign slot_tick = (cnt == CNT_LAST);

  // Prescaler: one slot_tick every REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       cnt <= '0;
    else if (slot_tick) cnt <= '0;
    else                cnt <= cnt + CNT_ONE;
  end

  // Slot index advance, and the once-per-frame digit snapshot with its pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= 2'd0;
      snap       <= 16'h0000;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (slot_tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          snap       <= {d3, d2, d1, d0};
          frame_tick <= 1'b1;
        end
      end
    end
  end

  // Select the snapshot digit for the current slot.
  always_comb begin
    digit = snap[3:0];
    case (idx)
      2'd0:    digit = snap[3:0];
      2'd1:    digit = snap[7:4];
      2'd2:    digit = snap[11:8];
      default: digit = snap[15:12];
    endcase
  end

  // Decide whether the current slot is dark (global blank or leading zero).
  always_comb begin
    slot_off = blank;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 2'd3 && snap[15:12] == 4'd0)
      slot_off = 1'b1;
    if (idx == 2'd2 && snap[15:12] == 4'd0 && snap[11:8] == 4'd0)
      slot_off = 1'b1;
`endif
  end

  // BCD to active-low {g,f,e,d,c,b,a}; anything above 9 shows a dash.
  always_comb begin
    seg_dec = 7'h3F;
    case (digit)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
  end

  // Pin values for this cycle; a dark slot drives every segment off so no ghosting.
  always_comb begin
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (!slot_off) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = seg_dec;
      dp_nxt  = (idx != 2'd1);
    end
  end

  // Output register: pins follow idx/snap/blank one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Scoreboarded bench for seg7_scan_driver with REFRESH_DIV=4 (16-cycle frame).
// A reference model predicts the pins after every clock edge from the edge
// count since reset and pushes them into a queue; a monitor pops and compares
// on the falling edge. Honours LEADING_ZERO_BLANK_EN when defined.
module tb_seg7_scan_driver;

  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } pins_t;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b1;
  logic [3:0] d0        = 4'd0;
  logic [3:0] d1        = 4'd0;
  logic [3:0] d2        = 4'd0;
  logic [3:0] d3        = 4'd0;
  logic       blank     = 1'b0;
  logic       rst_probe = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  pins_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    n      = 0;
  int    msnap[4];

  seg7_scan_driver #(.REFRESH_DIV(RD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: pins after edge n show slot ((n-1)/RD)%4 of the snapshot
  // taken at the last frame boundary; a new snapshot is taken every FRAME edges.
  always @(posedge clk or negedge reset_n) begin : model
    int    slot;
    int    lead;
    bit    off;
    pins_t e;
    if (!reset_n) begin
      n = 0;
      for (int i = 0; i < 4; i++) msnap[i] = 0;
      exp_q.delete();
    end else begin
      n++;
      slot = ((n - 1) / RD) % 4;
      lead = 0;
`ifdef LEADING_ZERO_BLANK_EN
      lead = (msnap[3] != 0) ? 0 : ((msnap[2] != 0) ? 1 : 2);
`endif
      off  = blank || (slot >= 4 - lead);
      e.an  = off ? 4'hF : (4'hF ^ 4'(1 << slot));
      e.seg = off ? 7'h7F : SEG_TAB[msnap[slot]];
      e.dp  = !(!off && slot == 1);
      e.ft  = (n % FRAME == 0);
      exp_q.push_back(e);
      if (n % FRAME == 0) begin
        msnap[0] = int'(d0);
        msnap[1] = int'(d1);
        msnap[2] = int'(d2);
        msnap[3] = int'(d3);
      end
    end
  end

  // Monitor: checks reset values on request, otherwise one expected entry per cycle.
  always @(negedge clk or posedge rst_probe) begin : monitor
    pins_t e;
    pins_t a;
    a = {an, seg, dp, frame_tick};
    if (rst_probe) begin
      checks++;
      if (a !== 13'b1111_1111111_1_0) begin
        errors++;
        $display("FAIL reset_state t=%0t got an=%b seg=%h dp=%b ft=%b want an=1111 seg=7f dp=1 ft=0",
                 $time, an, seg, dp, frame_tick);
      end
    end else if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL pins t=%0t got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 $time, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Assert reset in the middle of a cycle, probe pins, release on a falling edge.
  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1 rst_probe = 1'b1;
    #1 rst_probe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1 rst_probe = 1'b1;
    #1 rst_probe = 1'b0;
    {d3, d2, d1, d0} = 16'h4321;
    @(negedge clk);
    reset_n = 1'b1;
    step(40);
    step(6);
    d0 = 4'd7;
    step(30);
    d2 = 4'hC;
    step(36);
    blank = 1'b1;
    step(10);
    blank = 1'b0;
    step(24);
    {d3, d2, d1, d0} = 16'h0005;
    step(36);
    {d3, d2, d1, d0} = 16'h0305;
    step(34);
    pulse_reset();
    step(20);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) d0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) d1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) d2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) d3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) blank = ~blank;
      if ($urandom_range(0, 149) == 0) pulse_reset();
    end
    blank = 1'b0;
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
